// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions: response codes, register map of the companion slave,
// the master FSM state type and a saturating counter helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] REG_CTRL_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] REG_VERSION_OFFSET = 32'h0000_0004;
  localparam logic [31:0] REG_SCRATCH_OFFSET = 32'h0000_0008;

  localparam logic [31:0] IP_VERSION = 32'h0001_0002;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWr   = 2'b01,
    StRd   = 2'b10,
    StRsp  = 2'b11
  } axi4l_mst_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: takes one command, runs the AXI transfer and holds
// the response (with its measured latency) until the consumer takes it.
module axi4_lite_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [15:0]             rsp_cycles,

  axi4_lite_if.master             mst
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  axi4l_mst_state_e      state_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic [15:0]           rsp_cycles_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
      rsp_cycles_q <= 16'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q  <= 1'b0;
            addr_q       <= cmd_addr;
            wdata_q      <= cmd_wdata;
            wstrb_q      <= cmd_wstrb;
            rsp_write_q  <= cmd_write;
            rsp_cycles_q <= 16'd0;
            if (cmd_write) begin
              state_q   <= StWr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
            end else begin
              state_q   <= StRd;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end

        StWr: begin
          rsp_cycles_q <= sat_inc16(rsp_cycles_q);
          if (awvalid_q && mst.awready) awvalid_q <= 1'b0;
          if (wvalid_q && mst.wready) wvalid_q <= 1'b0;
          // An early B still ends the transfer; any unfinished AW/W is dropped with it.
          if (bready_q && mst.bvalid) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_resp_q  <= mst.bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end

        StRd: begin
          rsp_cycles_q <= sat_inc16(rsp_cycles_q);
          if (arvalid_q && mst.arready) arvalid_q <= 1'b0;
          if (rready_q && mst.rvalid) begin
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_resp_q  <= mst.rresp;
            rsp_rdata_q <= mst.rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end

        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_resp   = rsp_resp_q;
  assign rsp_cycles = rsp_cycles_q;

  assign mst.awaddr  = addr_q;
  assign mst.awprot  = 3'b000;
  assign mst.awvalid = awvalid_q;
  assign mst.wdata   = wdata_q;
  assign mst.wstrb   = wstrb_q;
  assign mst.wvalid  = wvalid_q;
  assign mst.bready  = bready_q;
  assign mst.araddr  = addr_q;
  assign mst.arprot  = 3'b000;
  assign mst.arvalid = arvalid_q;
  assign mst.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural register-map slave, scoreboard of expected
// responses and bus-protocol monitors sampled on the falling edge.
module tb_axi4_lite_master;
  import axi_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [15:0]   rsp_cycles;

  always #5 aclk = ~aclk;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_cycles (rsp_cycles),
    .mst        (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic          aw_got, w_got, ar_got;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_ctrl, s_scratch;
  logic [3:0]    s_wstrb;
  int unsigned   aw_delay = 0;
  int unsigned   aw_wait;

  assign bus.awready = bus.awvalid && !aw_got && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid && !w_got;
  assign bus.arready = bus.arvalid && !ar_got;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge aclk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; aw_wait <= 0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      s_ctrl <= '0; s_scratch <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1; s_awaddr <= bus.awaddr; aw_wait <= 0;
      end else if (bus.awvalid && !aw_got) begin
        aw_wait <= aw_wait + 1;
      end
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb;
      end
      if (aw_got && w_got && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        case (s_awaddr)
          REG_CTRL_OFFSET: begin
            s_ctrl <= merge(s_ctrl, s_wdata, s_wstrb); bus.bresp <= RESP_OKAY;
          end
          REG_SCRATCH_OFFSET: begin
            s_scratch <= merge(s_scratch, s_wdata, s_wstrb); bus.bresp <= RESP_OKAY;
          end
          default: bus.bresp <= RESP_SLVERR;
        endcase
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        ar_got <= 1'b1; s_araddr <= bus.araddr;
      end
      if (ar_got && !bus.rvalid) begin
        bus.rvalid <= 1'b1;
        case (s_araddr)
          REG_CTRL_OFFSET:    begin bus.rdata <= s_ctrl;     bus.rresp <= RESP_OKAY; end
          REG_VERSION_OFFSET: begin bus.rdata <= IP_VERSION; bus.rresp <= RESP_OKAY; end
          REG_SCRATCH_OFFSET: begin bus.rdata <= s_scratch;  bus.rresp <= RESP_OKAY; end
          default:            begin bus.rdata <= '0;         bus.rresp <= RESP_SLVERR; end
        endcase
      end
      if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0; ar_got <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int unsigned   meas = 0;
  logic          meas_on = 1'b0;
  logic          aw_on_prev = 1'b0, w_on_prev = 1'b0;
  logic          aw_hs_prev = 1'b0, w_hs_prev = 1'b0, ar_hs_prev = 1'b0;
  logic [AW-1:0] awaddr_prev = '0;
  logic [DW-1:0] wdata_prev = '0;

  always @(negedge aclk) begin
    if (areset) begin
      meas_on = 1'b0;
      aw_on_prev = 1'b0; w_on_prev = 1'b0;
      aw_hs_prev = 1'b0; w_hs_prev = 1'b0; ar_hs_prev = 1'b0;
    end else begin
      if (aw_hs_prev) check_eq("awvalid_drop", bus.awvalid, 1'b0);
      if (w_hs_prev)  check_eq("wvalid_drop", bus.wvalid, 1'b0);
      if (ar_hs_prev) check_eq("arvalid_drop", bus.arvalid, 1'b0);
      if (aw_on_prev && bus.awvalid) check_eq("awaddr_stable", bus.awaddr, awaddr_prev);
      if (w_on_prev && bus.wvalid)   check_eq("wdata_stable", bus.wdata, wdata_prev);

      // Latency: cycles from the accept edge up to and including the B/R handshake edge.
      if (cmd_valid && cmd_ready) begin
        meas = 0; meas_on = 1'b1;
      end else if (meas_on) begin
        meas++;
        if ((bus.bvalid && bus.bready) || (bus.rvalid && bus.rready)) meas_on = 1'b0;
      end

      if (rsp_valid && rsp_ready) begin
        check_eq("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("rsp_write", rsp_write, e.wr);
          check_eq("rsp_rdata", rsp_rdata, e.rdata);
          check_eq("rsp_resp", rsp_resp, e.resp);
          check_eq("rsp_cycles", rsp_cycles, meas);
        end
      end

      aw_on_prev  = bus.awvalid && !bus.awready;
      w_on_prev   = bus.wvalid && !bus.wready;
      aw_hs_prev  = bus.awvalid && bus.awready;
      w_hs_prev   = bus.wvalid && bus.wready;
      ar_hs_prev  = bus.arvalid && bus.arready;
      awaddr_prev = bus.awaddr;
      wdata_prev  = bus.wdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    logic acc = 1'b0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge aclk);
      acc = cmd_ready;
    end
    check_eq("cmd_accept", acc, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp,
                        input logic [31:0] exp_rdata, input int unsigned stall);
    logic got = 1'b0;
    logic done = 1'b0;
    sb.push_back('{wr: wr, rdata: exp_rdata, resp: exp_resp});
    rsp_ready = (stall == 0);
    issue(wr, addr, data, strb);
    if (stall != 0) begin
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge aclk);
        got = rsp_valid;
      end
      check_eq("rsp_arrive", got, 1'b1);
      for (int k = 0; k < int'(stall); k++) begin
        if (k != 0) @(negedge aclk);
        check_eq("stall_valid", rsp_valid, 1'b1);
        check_eq("stall_rdata", rsp_rdata, exp_rdata);
        check_eq("stall_cmd_ready", cmd_ready, 1'b0);
      end
      @(posedge aclk); #1;
      rsp_ready = 1'b1;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      done = rsp_valid && rsp_ready;
    end
    check_eq("rsp_done", done, 1'b1);
    @(posedge aclk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_awvalid"}, bus.awvalid, 1'b0);
    check_eq({tag, "_wvalid"}, bus.wvalid, 1'b0);
    check_eq({tag, "_bready"}, bus.bready, 1'b0);
    check_eq({tag, "_arvalid"}, bus.arvalid, 1'b0);
    check_eq({tag, "_rready"}, bus.rready, 1'b0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b0);
  endtask

  initial begin
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_quiet("rst");
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_resp", rsp_resp, 2'b00);
    check_eq("rst_cycles", rsp_cycles, 16'h0);
    check_eq("rst_write", rsp_write, 1'b0);
    check_eq("rst_awaddr", bus.awaddr, 32'h0);
    check_eq("rst_wdata", bus.wdata, 32'h0);
    check_eq("rst_wstrb", bus.wstrb, 4'h0);
    check_eq("rst_prot", {bus.awprot, bus.arprot}, 6'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("rdy_after_rst", cmd_ready, 1'b1);
    @(posedge aclk); #1;

    do_txn(1'b1, REG_CTRL_OFFSET, 32'hCAFE_BABE, 4'hF, RESP_OKAY, 32'h0, 0);
    do_txn(1'b0, REG_CTRL_OFFSET, 32'h0, 4'h0, RESP_OKAY, 32'hCAFE_BABE, 0);

    do_txn(1'b1, 32'h0000_0100, 32'hBAAD_F00D, 4'hF, RESP_SLVERR, 32'h0, 0);
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, RESP_SLVERR, 32'h0, 0);

    do_txn(1'b1, REG_SCRATCH_OFFSET, 32'hAABB_CCDD, 4'hF, RESP_OKAY, 32'h0, 0);
    do_txn(1'b1, REG_SCRATCH_OFFSET, 32'h1111_1111, 4'h1, RESP_OKAY, 32'h0, 0);
    do_txn(1'b0, REG_SCRATCH_OFFSET, 32'h0, 4'h0, RESP_OKAY, 32'hAABB_CC11, 0);

    do_txn(1'b0, REG_VERSION_OFFSET, 32'h0, 4'h0, RESP_OKAY, IP_VERSION, 5);

    // AW held off 3 cycles: W at edge 1, AW at edge 4, B raised edge 5, B taken edge 6.
    aw_delay = 3;
    do_txn(1'b1, REG_SCRATCH_OFFSET, 32'h1234_5678, 4'hF, RESP_OKAY, 32'h0, 0);
    check_eq("slow_aw_cycles", rsp_cycles, 16'd6);
    aw_delay = 0;
    do_txn(1'b0, REG_SCRATCH_OFFSET, 32'h0, 4'h0, RESP_OKAY, 32'h1234_5678, 0);

    // Reset while the write is stuck waiting for AW.
    aw_delay = 10;
    issue(1'b1, REG_CTRL_OFFSET, 32'hDEAD_BEEF, 4'hF);
    @(negedge aclk);
    check_eq("wr_pending", bus.awvalid, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_quiet("mid_rst");
    @(posedge aclk); #1;
    areset = 1'b0;
    aw_delay = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_eq("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    @(posedge aclk); #1;
    do_txn(1'b0, REG_CTRL_OFFSET, 32'h0, 4'h0, RESP_OKAY, 32'h0, 0);

    repeat (3) @(posedge aclk);
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "bench timed out");
  end

endmodule
